// File: rtl/alu_stim_checker.sv
// Self-running vector generator and result checker for the alu block.
// It drives LFSR-derived vectors, compares dut_out with gold every cycle, and keeps the first failing vector.
module alu_stim_checker #(
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vecs,
    input  logic [31:0]      seed,
    output logic [2:0]       funct,
    output logic [31:0]      in_a,
    output logic [31:0]      in_b,
    input  logic [31:0]      dut_out,
    input  logic [31:0]      gold,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       fail_funct,
    output logic [31:0]      fail_a,
    output logic [31:0]      fail_b,
    output logic [31:0]      fail_out,
    output logic [31:0]      fail_gold
);

    localparam logic [2:0]  OP_ZERO   = 3'd0;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] B_XOR     = 32'hA5A5_A5A5;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] n_q;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    function automatic logic [31:0] mix_b(input logic [31:0] v);
        return {v[15:0], v[31:16]} ^ B_XOR;
    endfunction

    // in_a doubles as the LFSR state, so the driven operand is always the current LFSR value
    logic             mismatch;
    logic             last;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      lfsr_nx;
    logic [31:0]      seed_ld;

    assign mismatch = (dut_out != gold);
    assign cnt_inc  = vec_count + 1'b1;
    assign last     = (cnt_inc == n_q) || (STOP_ON_FAIL && mismatch);
    assign lfsr_nx  = lfsr_step(in_a);
    assign seed_ld  = (seed == 32'd0) ? 32'd1 : seed;
    assign pass     = done && (err_count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            n_q        <= '0;
            funct      <= OP_ZERO;
            in_a       <= '0;
            in_b       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_funct <= OP_ZERO;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_out   <= '0;
            fail_gold  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_q        <= num_vecs;
                        funct      <= OP_ZERO;
                        in_a       <= seed_ld;
                        in_b       <= mix_b(seed_ld);
                        vec_count  <= '0;
                        err_count  <= '0;
                        fail_funct <= OP_ZERO;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_out   <= '0;
                        fail_gold  <= '0;
                        if (num_vecs == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    vec_count <= cnt_inc;
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        // err_count still zero means this is the run's first mismatch
                        if (err_count == '0) begin
                            fail_funct <= funct;
                            fail_a     <= in_a;
                            fail_b     <= in_b;
                            fail_out   <= dut_out;
                            fail_gold  <= gold;
                        end
                    end
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        in_a  <= lfsr_nx;
                        in_b  <= mix_b(lfsr_nx);
                        funct <= cnt_inc[2:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stim_checker.sv
// Bench for alu_stim_checker: a behavioural alu closes the loop, and a vector-list model predicts every cycle.
module tb_alu_stim_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_vecs = '0;
    logic [31:0] seed = '0;
    bit          fault = 1'b0;

    logic [2:0]  f0, ff0, f1, ff1;
    logic [31:0] a0, b0, o0, g0, fa0, fb0, fo0, fg0;
    logic [31:0] a1, b1, o1, g1, fa1, fb1, fo1, fg1;
    logic        busy0, done0, pass0, busy1, done1, pass1;
    logic [15:0] vc0, ec0, vc1, ec1;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0: return 32'd0;
            3'd1: return a + b;
            3'd2: return a - b;
            3'd3: return a << b[4:0];
            3'd4: return $unsigned($signed(a) >>> b[4:0]);
            3'd5: return a & b;
            3'd6: return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign g0 = alu_f(f0, a0, b0);
    assign o0 = g0 ^ {31'd0, fault && (f0 == 3'd1)};
    assign g1 = alu_f(f1, a1, b1);
    assign o1 = g1 ^ {31'd0, fault && (f1 == 3'd1)};

    alu_stim_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs), .seed(seed),
        .funct(f0), .in_a(a0), .in_b(b0), .dut_out(o0), .gold(g0),
        .busy(busy0), .done(done0), .pass(pass0), .vec_count(vc0), .err_count(ec0),
        .fail_funct(ff0), .fail_a(fa0), .fail_b(fb0), .fail_out(fo0), .fail_gold(fg0)
    );

    alu_stim_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vecs(num_vecs), .seed(seed),
        .funct(f1), .in_a(a1), .in_b(b1), .dut_out(o1), .gold(g1),
        .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
        .fail_funct(ff1), .fail_a(fa1), .fail_b(fb1), .fail_out(fo1), .fail_gold(fg1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: list the whole run's vectors up front, then walk the DUT cycle by cycle against the list
    task automatic run_vecs(input logic [31:0] sd, input int n, input bit restart_mid, input bit pin);
        logic [31:0] ea[64];
        logic [31:0] eb[64];
        logic [31:0] v;
        logic [31:0] gexp;
        int errs;
        int first;
        errs = 0;
        first = -1;
        v = (sd == 32'd0) ? 32'd1 : sd;
        for (int i = 0; i < n; i++) begin
            ea[i] = v;
            eb[i] = {v[15:0], v[31:16]} ^ 32'hA5A5_A5A5;
            v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
            if (fault && (i % 8 == 1)) begin
                errs++;
                if (first < 0) first = i;
            end
        end
        @(negedge clk);
        seed = sd;
        num_vecs = n[15:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("busy", {31'd0, busy0}, 32'd1);
            chk("done_in_run", {31'd0, done0}, 32'd0);
            chk("funct", {29'd0, f0}, i % 8);
            chk("in_a", a0, ea[i]);
            chk("in_b", b0, eb[i]);
            if (pin && i == 0) begin
                chk("pin_a0", a0, 32'h0000_0001);
                chk("pin_b0", b0, 32'hA5A4_A5A5);
            end
            if (pin && i == 1) begin
                chk("pin_a1", a0, 32'h8020_0003);
                chk("pin_b1", b0, 32'hA5A6_2585);
            end
            start = restart_mid && (i == 2);
            if (restart_mid && i == 2) seed = 32'hDEAD_BEEF;
            @(negedge clk);
            start = 1'b0;
        end
        chk("done", {31'd0, done0}, 32'd1);
        chk("busy_end", {31'd0, busy0}, 32'd0);
        chk("pass", {31'd0, pass0}, {31'd0, errs == 0});
        chk("vec_count", {16'd0, vc0}, n);
        chk("err_count", {16'd0, ec0}, errs);
        if (n > 0) begin
            chk("hold_a", a0, ea[n-1]);
            chk("hold_funct", {29'd0, f0}, (n - 1) % 8);
        end
        if (errs > 0) begin
            gexp = ea[first] + eb[first];
            chk("fail_funct", {29'd0, ff0}, 32'd1);
            chk("fail_a", fa0, ea[first]);
            chk("fail_b", fb0, eb[first]);
            chk("fail_gold", fg0, gexp);
            chk("fail_out", fo0, gexp ^ 32'd1);
        end else begin
            chk("fail_a_clear", fa0, 32'd0);
        end
        chk("s_done", {31'd0, done1}, 32'd1);
        chk("s_vec_count", {16'd0, vc1}, (errs > 0) ? first + 1 : n);
        chk("s_err_count", {16'd0, ec1}, (errs > 0) ? 1 : 0);
        chk("s_pass", {31'd0, pass1}, {31'd0, errs == 0});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_funct", {29'd0, f0}, 32'd0);
        chk("rst_a", a0, 32'd0);
        chk("rst_b", b0, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_pass", {31'd0, pass0}, 32'd0);
        chk("rst_err", {16'd0, ec0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy0}, 32'd0);

        run_vecs(32'd1, 8, 1'b0, 1'b1);
        run_vecs(32'h1234_5678, 0, 1'b0, 1'b0);
        run_vecs(32'h0BAD_F00D, 8, 1'b1, 1'b0);
        fault = 1'b1;
        run_vecs(32'h0000_0007, 16, 1'b0, 1'b0);
        fault = 1'b0;
        run_vecs(32'd0, 8, 1'b0, 1'b1);

        // Asynchronous reset while vector 5 is on the outputs
        @(negedge clk);
        seed = 32'h5555_AAAA;
        num_vecs = 16'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_vc", {16'd0, vc0}, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_a", a0, 32'd0);
        chk("arst_b", b0, 32'd0);
        chk("arst_funct", {29'd0, f0}, 32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_vc", {16'd0, vc0}, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_done", {31'd0, done0}, 32'd0);
        run_vecs(32'd1, 8, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
